// File: rtl/keypad_pkg.sv
// Key codes, scan-position decode and debounce state encoding shared by the keypad entry path.
// Pure definitions; no timing or flow control.
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    localparam key_code_t K0    = 4'd0;
    localparam key_code_t K1    = 4'd1;
    localparam key_code_t K2    = 4'd2;
    localparam key_code_t K3    = 4'd3;
    localparam key_code_t K4    = 4'd4;
    localparam key_code_t K5    = 4'd5;
    localparam key_code_t K6    = 4'd6;
    localparam key_code_t K7    = 4'd7;
    localparam key_code_t K8    = 4'd8;
    localparam key_code_t K9    = 4'd9;
    localparam key_code_t KSTAR = 4'd10;
    localparam key_code_t KHASH = 4'd11;
    // Op keys sit at 12..15 so that code[1:0] is directly the op select.
    localparam key_code_t KA    = 4'd12;
    localparam key_code_t KB    = 4'd13;
    localparam key_code_t KC    = 4'd14;
    localparam key_code_t KD    = 4'd15;

    // All 16 codes are real keys, so a frame result carries an extra "no single key" bit.
    typedef logic [4:0] frame_code_t;
    localparam frame_code_t KNONE = 5'h10;

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} scan_state_t;

    function automatic key_code_t key_at(input logic [1:0] r, input logic [1:0] c);
        key_code_t k;
        case ({r, c})
            4'h0: k = K1;    4'h1: k = K2;    4'h2: k = K3;    4'h3: k = KA;
            4'h4: k = K4;    4'h5: k = K5;    4'h6: k = K6;    4'h7: k = KB;
            4'h8: k = K7;    4'h9: k = K8;    4'hA: k = K9;    4'hB: k = KC;
            4'hC: k = KSTAR; 4'hD: k = K0;    4'hE: k = KHASH; default: k = KD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scan, row synchronizer, frame decode and debounce; one key_event pulse per press.
// Event lands on the frame-end cycle that completes debounce; keypad has no backpressure.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_event,
    output key_code_t   key_code
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [DW-1:0] div_cnt;
    logic [1:0]    col_idx;
    logic [3:0]    row_s1, row_s2;
    logic [1:0]    fr_hits;
    key_code_t     fr_code;
    logic          dwell_end, frame_end;
    logic [2:0]    col_hits, tot_hits;
    key_code_t     col_code;
    frame_code_t   frame_code;

    scan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    key_code_t     code_q, code_d;

    assign dwell_end = (div_cnt == DW'(SCAN_DIV - 1));
    assign frame_end = dwell_end && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);

    always_comb begin
        col_hits = 3'd0;
        col_code = K0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = key_at(2'(r), col_idx);
            end
        end
        tot_hits   = {1'b0, fr_hits} + col_hits;
        frame_code = (tot_hits == 3'd1) ? {1'b0, (fr_hits == 2'd1) ? fr_code : col_code} : KNONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1  <= 4'hF;
            row_s2  <= 4'hF;
            div_cnt <= '0;
            col_idx <= 2'd0;
            fr_hits <= 2'd0;
            fr_code <= K0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (dwell_end) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    fr_hits <= 2'd0;
                end else begin
                    // Saturate at 2: only "none / one / many" matters for the frame result.
                    fr_hits <= (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
                    if (col_hits != 3'd0) fr_code <= col_code;
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= K0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        key_event = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: if (!frame_code[4]) begin
                    code_d = frame_code[3:0];
                    cnt_d  = CW'(1);
                    if (DEBOUNCE_SCANS == 1) begin
                        state_d   = HELD;
                        key_event = 1'b1;
                    end else begin
                        state_d = CONFIRM;
                    end
                end
                CONFIRM: if (frame_code == {1'b0, code_q}) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(DEBOUNCE_SCANS)) begin
                        state_d   = HELD;
                        key_event = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
                HELD: if (frame_code[4]) begin
                    cnt_d   = CW'(1);
                    state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                end
                default: if (frame_code[4]) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(DEBOUNCE_SCANS)) state_d = IDLE;
                end else begin
                    state_d = HELD;
                end
            endcase
        end
    end

    assign key_code = code_d;

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: decimal accumulation, enter/clear, op-select events.
// Outputs registered one clk after the scanner event; no backpressure, pulses are single-cycle.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int MAX_DIGITS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] operand,
    output logic       operand_valid,
    output logic [1:0] op_sel,
    output logic       op_valid,
    output logic [1:0] digit_count,
    output logic       overflow,
    output logic       entry_error
);

    logic       key_event;
    key_code_t  key_code;
    logic [7:0] acc;
    logic [11:0] next_val;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_event (key_event),
        .key_code  (key_code)
    );

    // Wide enough that acc*10+d can never wrap, whatever MAX_DIGITS is.
    assign next_val = {4'b0, acc} * 12'd10 + {8'b0, key_code};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc           <= 8'd0;
            operand       <= 8'd0;
            operand_valid <= 1'b0;
            op_sel        <= 2'b00;
            op_valid      <= 1'b0;
            digit_count   <= 2'd0;
            overflow      <= 1'b0;
            entry_error   <= 1'b0;
        end else begin
            operand_valid <= 1'b0;
            op_valid      <= 1'b0;
            entry_error   <= 1'b0;
            if (key_event) begin
                if (key_code <= K9) begin
                    if (overflow || int'(digit_count) >= MAX_DIGITS || next_val > 12'd255) begin
                        overflow <= 1'b1;
                    end else begin
                        acc         <= next_val[7:0];
                        digit_count <= digit_count + 2'd1;
                    end
                end else if (key_code == KHASH || key_code == KSTAR) begin
                    if (key_code == KHASH) begin
                        if (overflow) begin
                            entry_error <= 1'b1;
                        end else begin
                            operand       <= acc;
                            operand_valid <= 1'b1;
                        end
                    end
                    acc         <= 8'd0;
                    digit_count <= 2'd0;
                    overflow    <= 1'b0;
                end else begin
                    op_sel   <= key_code[1:0];
                    op_valid <= 1'b1;
                end
            end
        end
    end

endmodule
